// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronises and debounces raw board push-buttons, producing
//            clean levels plus one-clock press/release pulses.
//            Optional auto-repeat of press pulses: BUTTON_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_held
);

    localparam int               c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    // Acceptance happens on the edge that sees the DEBOUNCE_CYCLES-th stable sample.
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int               c_rep_max         = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                                     REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               c_rep_w           = $clog2(c_rep_max + 1);
    localparam logic [c_rep_w-1:0] c_rep_one         = c_rep_w'(1);
    localparam logic [c_rep_w-1:0] c_rep_delay_last  = c_rep_w'(REPEAT_DELAY - 1);
    localparam logic [c_rep_w-1:0] c_rep_period_last = c_rep_w'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESS_CHK = 2'd1,
        S_HELD      = 2'd2,
        S_REL_CHK   = 2'd3
    } state_t;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            state_t             r_state;
            logic [c_cnt_w-1:0] r_cnt;
            logic               r_level;
            logic               r_press;
            logic               r_release;
            logic               w_rep_fire;

`ifdef BUTTON_AUTOREPEAT_EN
            if (gi == 4) begin : g_no_rep
                assign w_rep_fire = 1'b0;
            end else begin : g_rep
                logic [c_rep_w-1:0] r_rep_cnt;
                logic               r_rep_first;

                assign w_rep_fire = (r_state == S_HELD) && r_sync2[gi] &&
                                    (r_rep_first ? (r_rep_cnt == c_rep_delay_last)
                                                 : (r_rep_cnt == c_rep_period_last));

                // Counts only while staying in HELD, so REL_CHK freezes it.
                always_ff @(posedge clk) begin
                    if (rst || (r_state == S_IDLE)) begin
                        r_rep_cnt   <= '0;
                        r_rep_first <= 1'b1;
                    end else if ((r_state == S_HELD) && r_sync2[gi]) begin
                        if (w_rep_fire) begin
                            r_rep_cnt   <= '0;
                            r_rep_first <= 1'b0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + c_rep_one;
                        end
                    end
                end
            end
`else
            assign w_rep_fire = 1'b0;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    case (r_state)
                        S_IDLE: begin
                            if (r_sync2[gi]) begin
                                r_state <= S_PRESS_CHK;
                                r_cnt   <= c_cnt_one;
                            end
                        end
                        S_PRESS_CHK: begin
                            if (!r_sync2[gi]) begin
                                r_state <= S_IDLE;
                                r_cnt   <= '0;
                            end else if (r_cnt == c_cnt_last) begin
                                r_state <= S_HELD;
                                r_cnt   <= '0;
                                r_level <= 1'b1;
                                r_press <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + c_cnt_one;
                            end
                        end
                        S_HELD: begin
                            if (!r_sync2[gi]) begin
                                r_state <= S_REL_CHK;
                                r_cnt   <= c_cnt_one;
                            end else if (w_rep_fire) begin
                                r_press <= 1'b1;
                            end
                        end
                        S_REL_CHK: begin
                            if (r_sync2[gi]) begin
                                r_state <= S_HELD;
                                r_cnt   <= '0;
                            end else if (r_cnt == c_cnt_last) begin
                                r_state   <= S_IDLE;
                                r_cnt     <= '0;
                                r_level   <= 1'b0;
                                r_release <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + c_cnt_one;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end
                    endcase
                end
            end

            assign btn_level[gi]   = r_level;
            assign btn_press[gi]   = r_press;
            assign btn_release[gi] = r_release;
        end
    endgenerate

    assign any_held = |btn_level;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Scoreboard bench for button_conditioner (DEBOUNCE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int c_lat = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_raw = '0;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic       any_held;

    button_conditioner #(
        .N_BTN           (5),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_held    (any_held)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [4:0] press;
        logic [4:0] rel;
        logic [4:0] level;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sb_push(input int dly, input logic [4:0] press,
                           input logic [4:0] rel, input logic [4:0] level);
        exp_t e;
        e.cyc   = cyc + dly;
        e.press = press;
        e.rel   = rel;
        e.level = level;
        q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever a pulse appears.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                fails++;
                $display("FAIL missed_pulse: no pulse by cycle %0d, required press=%b release=%b at cycle %0d",
                         cyc, q[0].press, q[0].rel, q[0].cyc);
                void'(q.pop_front());
            end
            if ((btn_press | btn_release) != 5'b0) begin
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_pulse: cycle %0d got press=%b release=%b, required none",
                             cyc, btn_press, btn_release);
                end else begin
                    e = q.pop_front();
                    check("press",    32'(btn_press),   32'(e.press));
                    check("release",  32'(btn_release), 32'(e.rel));
                    check("level",    32'(btn_level),   32'(e.level));
                    check("any_held", 32'(any_held),    32'(|e.level));
                end
            end
        end
    end

    initial begin : stimulus
        rst     = 1'b1;
        btn_raw = '0;
        tick(2);
        check("reset_level",   32'(btn_level),   32'd0);
        check("reset_press",   32'(btn_press),   32'd0);
        check("reset_release", 32'(btn_release), 32'd0);
        check("reset_any",     32'(any_held),    32'd0);
        rst = 1'b0;
        tick(2);

        // Single clean press and release on bit 0
        btn_raw[0] = 1'b1;
        sb_push(c_lat, 5'b00001, 5'b00000, 5'b00001);
        tick(10);
        btn_raw[0] = 1'b0;
        sb_push(c_lat, 5'b00000, 5'b00001, 5'b00000);
        tick(10);

        // Bounce on bit 1: short pulses are rejected
        btn_raw[1] = 1'b1; tick(2);
        btn_raw[1] = 1'b0; tick(2);
        btn_raw[1] = 1'b1; tick(2);
        btn_raw[1] = 1'b0; tick(2);
        btn_raw[1] = 1'b1;
        sb_push(c_lat, 5'b00010, 5'b00000, 5'b00010);
        tick(8);
        btn_raw[1] = 1'b0;
        sb_push(c_lat, 5'b00000, 5'b00010, 5'b00000);
        tick(10);

        // Bit 2 released with bounce
        btn_raw[2] = 1'b1;
        sb_push(c_lat, 5'b00100, 5'b00000, 5'b00100);
        tick(8);
        btn_raw[2] = 1'b0; tick(1);
        btn_raw[2] = 1'b1; tick(1);
        btn_raw[2] = 1'b0;
        sb_push(c_lat, 5'b00000, 5'b00100, 5'b00000);
        tick(10);

        // Simultaneous press on bits 0 and 1
        btn_raw = 5'b00011;
        sb_push(c_lat, 5'b00011, 5'b00000, 5'b00011);
        tick(8);
        btn_raw = 5'b00000;
        sb_push(c_lat, 5'b00000, 5'b00011, 5'b00000);
        tick(10);

        // Reset while bit 3 held: no release pulse, fresh press afterwards
        btn_raw[3] = 1'b1;
        sb_push(c_lat, 5'b01000, 5'b00000, 5'b01000);
        tick(8);
        check("held_level3", 32'(btn_level), 32'b01000);
        rst = 1'b1;
        tick(1);
        check("rst_level", 32'(btn_level), 32'd0);
        check("rst_any",   32'(any_held),  32'd0);
        rst = 1'b0;
        sb_push(c_lat, 5'b01000, 5'b00000, 5'b01000);
        tick(8);
        btn_raw[3] = 1'b0;
        sb_push(c_lat, 5'b00000, 5'b01000, 5'b00000);
        tick(10);

        // Long hold on bit 0 (auto-repeats when enabled)
        btn_raw[0] = 1'b1;
        sb_push(c_lat, 5'b00001, 5'b00000, 5'b00001);
`ifdef BUTTON_AUTOREPEAT_EN
        sb_push(c_lat + 8,  5'b00001, 5'b00000, 5'b00001);
        sb_push(c_lat + 11, 5'b00001, 5'b00000, 5'b00001);
        sb_push(c_lat + 14, 5'b00001, 5'b00000, 5'b00001);
        sb_push(c_lat + 17, 5'b00001, 5'b00000, 5'b00001);
`endif
        tick(22);
        btn_raw[0] = 1'b0;
        sb_push(c_lat, 5'b00000, 5'b00001, 5'b00000);
        tick(10);

        // Long hold on centre: never repeats
        btn_raw[4] = 1'b1;
        sb_push(c_lat, 5'b10000, 5'b00000, 5'b10000);
        tick(22);
        btn_raw[4] = 1'b0;
        sb_push(c_lat, 5'b00000, 5'b10000, 5'b00000);
        tick(12);

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
